// File: rtl/rgb_frame_sequencer.sv
// rtl/rgb_frame_sequencer.sv - frame walker feeding a combinational RGB converter
//
// Purpose:
//   Walks an IMG_W x IMG_H frame that is stored as three planar memories.
//   For each pixel it issues one read, registers the R/G/B words into the
//   converter inputs, and captures the converter result. The result is then
//   presented on a valid/ready stream. Start, done and abort frame the sequence.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_start, i_abort    begin frame (IDLE only) / cancel frame (any non-IDLE)
//   o_busy, o_done      non-IDLE indicator / one-cycle end-of-frame pulse
//   o_mem_rd_en         read strobe shared by the three plane memories
//   o_mem_addr          pixel index y*IMG_W + x
//   i_mem_r/g/b         plane data, valid the cycle after o_mem_rd_en
//   o_conv_r/g/b        registered converter inputs
//   i_conv_out          combinational converter result
//   o_out_valid         output stream valid
//   i_out_ready         output stream ready
//   o_out_data          output stream data
//   o_pix_x, o_pix_y    coordinates of the pixel in flight
module rgb_frame_sequencer #(
  parameter int IMG_W = 500,
  parameter int IMG_H = 500,
  parameter int DW    = 32,
  parameter int AW    = 18
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_abort,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_mem_rd_en,
  output logic [AW-1:0] o_mem_addr,
  input  logic [DW-1:0] i_mem_r,
  input  logic [DW-1:0] i_mem_g,
  input  logic [DW-1:0] i_mem_b,
  output logic [DW-1:0] o_conv_r,
  output logic [DW-1:0] o_conv_g,
  output logic [DW-1:0] o_conv_b,
  input  logic [DW-1:0] i_conv_out,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic [DW-1:0] o_out_data,
  output logic [15:0]   o_pix_x,
  output logic [15:0]   o_pix_y
);

  localparam int NPIX = IMG_W * IMG_H;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LOAD,
    S_CAPT,
    S_HOLD,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic          r_busy;
  logic          r_done;
  logic          r_rd_en;
  logic          r_valid;
  logic [AW-1:0] r_idx;
  logic [15:0]   r_x;
  logic [15:0]   r_y;
  logic [DW-1:0] r_conv_r;
  logic [DW-1:0] r_conv_g;
  logic [DW-1:0] r_conv_b;
  logic [DW-1:0] r_out_data;

  logic w_accept;
  logic w_last;
  logic w_row_end;
  logic w_frame_start;

  assign w_last    = (r_idx == AW'(NPIX - 1));
  assign w_row_end = (r_x == 16'(IMG_W - 1));

  // Next-state logic. Abort is evaluated ahead of the case so that it
  // overrides a handshake in HOLD: that pixel is never counted as accepted.
  always_comb begin
    w_state_nxt   = r_state;
    w_accept      = 1'b0;
    w_frame_start = 1'b0;
    if (r_state != S_IDLE && i_abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            w_state_nxt   = S_READ;
            w_frame_start = 1'b1;
          end
        end
        S_READ: w_state_nxt = S_LOAD;
        S_LOAD: w_state_nxt = S_CAPT;
        S_CAPT: w_state_nxt = S_HOLD;
        S_HOLD: begin
          if (i_out_ready) begin
            w_accept    = 1'b1;
            w_state_nxt = w_last ? S_DONE : S_READ;
          end
        end
        S_DONE: w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Status strobes are decoded from the next state so that they line up
  // with the state they describe while still coming straight from flops.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rd_en <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= (w_state_nxt == S_DONE);
      r_rd_en <= (w_state_nxt == S_READ);
      r_valid <= (w_state_nxt == S_HOLD);
    end
  end

  // Pixel index and coordinates advance only on an accepted, non-final pixel
  // so that they keep describing the pixel in flight until it leaves.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idx <= '0;
      r_x   <= '0;
      r_y   <= '0;
    end else if (w_frame_start) begin
      r_idx <= '0;
      r_x   <= '0;
      r_y   <= '0;
    end else if (w_accept && !w_last) begin
      r_idx <= r_idx + AW'(1);
      if (w_row_end) begin
        r_x <= '0;
        r_y <= r_y + 16'd1;
      end else begin
        r_x <= r_x + 16'd1;
      end
    end
  end

  // Converter inputs and the captured result are loaded only in their own
  // state and hold otherwise.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_conv_r   <= '0;
      r_conv_g   <= '0;
      r_conv_b   <= '0;
      r_out_data <= '0;
    end else begin
      if (r_state == S_LOAD) begin
        r_conv_r <= i_mem_r;
        r_conv_g <= i_mem_g;
        r_conv_b <= i_mem_b;
      end
      if (r_state == S_CAPT) begin
        r_out_data <= i_conv_out;
      end
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_mem_rd_en = r_rd_en;
  assign o_mem_addr  = r_idx;
  assign o_conv_r    = r_conv_r;
  assign o_conv_g    = r_conv_g;
  assign o_conv_b    = r_conv_b;
  assign o_out_valid = r_valid;
  assign o_out_data  = r_out_data;
  assign o_pix_x     = r_x;
  assign o_pix_y     = r_y;

endmodule

// File: tb/tb_rgb_frame_sequencer.sv
// tb/tb_rgb_frame_sequencer.sv - directed/random bench for rgb_frame_sequencer
module tb_rgb_frame_sequencer;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int N  = W * H;
  localparam int DW = 32;
  localparam int AW = 18;

  logic          clk = 1'b0;
  logic          rst, start, abort, ready;
  logic          busy, done, rd_en, valid;
  logic [AW-1:0] addr;
  logic [DW-1:0] mem_r, mem_g, mem_b;
  logic [DW-1:0] conv_r, conv_g, conv_b, conv_out, out_data;
  logic [15:0]   pix_x, pix_y;

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] pr [16];
  logic [31:0] pg [16];
  logic [31:0] pb [16];

  always #5 clk = ~clk;

  rgb_frame_sequencer #(.IMG_W(W), .IMG_H(H), .DW(DW), .AW(AW)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
    .o_busy(busy), .o_done(done), .o_mem_rd_en(rd_en), .o_mem_addr(addr),
    .i_mem_r(mem_r), .i_mem_g(mem_g), .i_mem_b(mem_b),
    .o_conv_r(conv_r), .o_conv_g(conv_g), .o_conv_b(conv_b),
    .i_conv_out(conv_out), .o_out_valid(valid), .i_out_ready(ready),
    .o_out_data(out_data), .o_pix_x(pix_x), .o_pix_y(pix_y)
  );

  // Plane memories with one cycle of read latency
  always @(posedge clk) begin
    if (rd_en) begin
      mem_r <= pr[addr[3:0]];
      mem_g <= pg[addr[3:0]];
      mem_b <= pb[addr[3:0]];
    end
  end

  assign conv_out = conv_r ^ (conv_g + conv_b);

  function automatic logic [31:0] ref_pix(input int i);
    return pr[i[3:0]] ^ (pg[i[3:0]] + pb[i[3:0]]);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill();
    for (int i = 0; i < 16; i++) begin
      pr[i[3:0]] = $urandom;
      pg[i[3:0]] = $urandom;
      pb[i[3:0]] = $urandom;
    end
  endtask

  // rmode: 0 ready always, 1 ready one cycle in three, 2 random ready
  task automatic run_frame(input int rmode, input int abort_pix, input bit noisy_start);
    int          got = 0;
    int          nreads = 0;
    bit          fin = 0;
    bit          pvalid = 0;
    bit          pacc = 0;
    logic [31:0] pdata = '0;
    @(negedge clk);
    start = 1'b1;
    ready = (rmode == 1) ? 1'b0 : 1'b1;
    for (int k = 1; k <= 3000 && !fin; k++) begin
      @(negedge clk);
      start = noisy_start ? 1'($urandom_range(0, 1)) : 1'b0;
      if (k == 1) begin
        chk("first_busy", busy, 1);
        chk("first_rd", rd_en, 1);
        chk("first_addr", addr, 0);
      end
      if (rd_en) begin
        nreads++;
        chk("rd_while_valid", valid, 0);
      end
      if (rmode == 0 && k == 4) chk("first_valid", valid, 1);
      if (pvalid && !pacc && valid) chk("stall_stable", out_data, pdata);
      case (rmode)
        0:       ready = 1'b1;
        1:       ready = (k % 3 == 0);
        default: ready = 1'($urandom_range(0, 1));
      endcase
      if (valid && got == abort_pix) begin
        abort = 1'b1;
        ready = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_valid", valid, 0);
        chk("abort_rd", rd_en, 0);
        chk("abort_done", done, 0);
        chk("abort_count", got, abort_pix);
        @(negedge clk);
        chk("abort_no_done", done, 0);
        chk("abort_idle", busy, 0);
        return;
      end
      pacc   = valid && ready;
      pvalid = valid;
      pdata  = out_data;
      if (pacc) begin
        chk("pix_data", out_data, ref_pix(got));
        chk("pix_x", pix_x, got % W);
        chk("pix_y", pix_y, got / W);
        got++;
      end
      if (done) begin
        if (rmode == 0) chk("done_cycle", k, 4 * N + 1);
        chk("done_count", got, N);
        chk("reads", nreads, N);
        fin = 1;
        // start during the DONE cycle must not launch a frame
        if (noisy_start) start = 1'b1;
      end
    end
    if (!fin) chk("frame_timeout", 0, 1);
    @(negedge clk);
    start = 1'b0;
    chk("done_pulse_len", done, 0);
    chk("idle_after_done", busy, 0);
    @(negedge clk);
    chk("still_idle", busy, 0);
    chk("no_second_done", done, 0);
  endtask

  initial begin
    int nr;
    rst = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b0;
    fill();
    repeat (3) @(negedge clk);
    start = 1'b1;
    ready = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd", rd_en, 0);
    chk("rst_valid", valid, 0);
    chk("rst_addr", addr, 0);
    chk("rst_data", out_data, 0);
    chk("rst_conv", {conv_r, conv_g}, 0);
    chk("rst_xy", {pix_x, pix_y}, 0);
    rst = 1'b0;
    start = 1'b0;

    run_frame(0, -1, 0);
    fill();
    run_frame(1, -1, 0);
    fill();
    run_frame(2, 5, 0);
    run_frame(0, -1, 0);

    // reset while the third pixel is in LOAD
    fill();
    @(negedge clk);
    start = 1'b1;
    ready = 1'b1;
    nr = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (nr == 3) break;
      if (rd_en) nr++;
    end
    chk("rst_mid_reads", nr, 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", valid, 0);
    chk("midrst_rd", rd_en, 0);
    chk("midrst_addr", addr, 0);
    chk("midrst_conv", {conv_r, conv_g, conv_b}, 0);
    chk("midrst_data", out_data, 0);
    chk("midrst_xy", {pix_x, pix_y}, 0);
    run_frame(0, -1, 0);

    fill();
    run_frame(2, -1, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
